// File: rtl/sliding_window_gen_fp16.sv
// Raster-order FP16 pixel stream to WINDOW_HEIGHT x WINDOW_WIDTH interior windows, centre-tagged.
// Optional start-of-frame input sof_i enabled by defining WINDOW_GEN_SOF_EN.
module sliding_window_gen_fp16 #(
  parameter int unsigned EXP_WIDTH     = 5,
  parameter int unsigned FRAC_WIDTH    = 10,
  parameter int unsigned WINDOW_WIDTH  = 3,
  parameter int unsigned WINDOW_HEIGHT = 3,
  parameter int unsigned IMAGE_WIDTH   = 640,
  parameter int unsigned IMAGE_HEIGHT  = 480,
  parameter int unsigned FP_WIDTH_REG  = 1 + FRAC_WIDTH + EXP_WIDTH
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_i,
  input  logic [FP_WIDTH_REG-1:0]                                   data_i,
  input  logic                                                      valid_i,
`ifdef WINDOW_GEN_SOF_EN
  input  logic                                                      sof_i,
`endif
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
  output logic [15:0]                                               col_o,
  output logic [15:0]                                               row_o,
  output logic                                                      valid_o
);

  localparam int unsigned CW     = 16;
  localparam int unsigned AW     = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned NLB    = (WINDOW_HEIGHT > 1) ? WINDOW_HEIGHT - 1 : 1;
  localparam int unsigned HALF_W = (WINDOW_WIDTH - 1) / 2;
  localparam int unsigned HALF_H = (WINDOW_HEIGHT - 1) / 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(WINDOW_WIDTH - 1);
  localparam logic [CW-1:0] ROW_MIN  = CW'(WINDOW_HEIGHT - 1);

  typedef enum logic {
    ST_FILL,
    ST_STREAM
  } state_e;

  typedef logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] win_t;

  state_e            state_q, state_d;
  logic [CW-1:0]     in_col_q, in_col_d;
  logic [CW-1:0]     in_row_q, in_row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     row_q, row_d;
  logic              valid_q, valid_d;
  win_t              win_q, win_d;

  logic              sof_c;
  logic [CW-1:0]     cur_col_c;
  logic [CW-1:0]     cur_row_c;
  logic [AW-1:0]     addr_c;
  logic [FP_WIDTH_REG-1:0] lb_q     [NLB][IMAGE_WIDTH];
  logic [FP_WIDTH_REG-1:0] lb_rd_c  [NLB];
  logic [FP_WIDTH_REG-1:0] new_col_c[WINDOW_HEIGHT];

`ifdef WINDOW_GEN_SOF_EN
  assign sof_c = valid_i & sof_i;
`else
  assign sof_c = 1'b0;
`endif

  // Position of the pixel being accepted; a start-of-frame pixel is always (0,0).
  assign cur_col_c = sof_c ? '0 : in_col_q;
  assign cur_row_c = sof_c ? '0 : in_row_q;
  assign addr_c    = AW'(cur_col_c);

  always_comb begin
    for (int k = 0; k < NLB; k++) begin
      lb_rd_c[k] = lb_q[k][addr_c];
    end
  end

  // Line buffers cascade row by row; contents are never cleared, FILL masks stale rows.
  always_ff @(posedge clk_i) begin
    if (valid_i) begin
      lb_q[0][addr_c] <= data_i;
      for (int k = 1; k < NLB; k++) begin
        lb_q[k][addr_c] <= lb_rd_c[k-1];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < WINDOW_HEIGHT - 1; r++) begin
      new_col_c[r] = lb_rd_c[WINDOW_HEIGHT-2-r];
    end
    new_col_c[WINDOW_HEIGHT-1] = data_i;
  end

  always_comb begin
    win_d = win_q;
    if (valid_i) begin
      for (int r = 0; r < WINDOW_HEIGHT; r++) begin
        for (int c = 0; c < WINDOW_WIDTH - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][WINDOW_WIDTH-1] = new_col_c[r];
      end
    end
  end

  // Raster counters, FILL/STREAM state and output gating.
  always_comb begin
    state_d  = state_q;
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    valid_d  = 1'b0;
    col_d    = col_q;
    row_d    = row_q;
    if (valid_i) begin
      if (cur_col_c == COL_LAST) begin
        in_col_d = '0;
        in_row_d = (cur_row_c == ROW_LAST) ? '0 : CW'(cur_row_c + 16'd1);
      end else begin
        in_col_d = CW'(cur_col_c + 16'd1);
        in_row_d = cur_row_c;
      end
      state_d = (in_row_d >= ROW_MIN) ? ST_STREAM : ST_FILL;
      if (!sof_c && (state_q == ST_STREAM) && (in_col_q >= COL_MIN)) begin
        valid_d = 1'b1;
        col_d   = CW'(in_col_q - CW'(HALF_W));
        row_d   = CW'(in_row_q - CW'(HALF_H));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_FILL;
      in_col_q <= '0;
      in_row_q <= '0;
      valid_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      valid_q  <= valid_d;
      col_q    <= col_d;
      row_q    <= row_d;
      win_q    <= win_d;
    end
  end

  assign window_o = win_q;
  assign col_o    = col_q;
  assign row_o    = row_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_sliding_window_gen_fp16.sv
// Self-checking bench for sliding_window_gen_fp16 on an 8x6 image with a 3x3 window.
module tb_sliding_window_gen_fp16;

  localparam int unsigned IW = 8;
  localparam int unsigned IH = 6;
  localparam int unsigned W  = 3;
  localparam int unsigned H  = 3;

  logic                           clk_i = 1'b0;
  logic                           rst_i;
  logic [15:0]                    data_i;
  logic                           valid_i;
  logic                           sof_i;
  logic [H-1:0][W-1:0][15:0]      window_o;
  logic [15:0]                    col_o;
  logic [15:0]                    row_o;
  logic                           valid_o;

  sliding_window_gen_fp16 #(
    .EXP_WIDTH    (5),
    .FRAC_WIDTH   (10),
    .WINDOW_WIDTH (W),
    .WINDOW_HEIGHT(H),
    .IMAGE_WIDTH  (IW),
    .IMAGE_HEIGHT (IH)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
`ifdef WINDOW_GEN_SOF_EN
    .sof_i   (sof_i),
`endif
    .window_o(window_o),
    .col_o   (col_o),
    .row_o   (row_o),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the current frame as a 2D image plus a raster position.
  logic [15:0]              pix [IH][IW];
  int                       m_col, m_row;
  logic                     exp_v;
  logic [15:0]              exp_col, exp_row;
  logic [H-1:0][W-1:0][15:0] exp_w;
  int                       n_checks, n_fail, pulses;

  task automatic step(input logic v, input logic [15:0] d, input logic s);
    int c, r;
    valid_i = v;
    data_i  = d;
    sof_i   = s;
    @(posedge clk_i);
    #1;
    exp_v = 1'b0;
    if (v) begin
      c = s ? 0 : m_col;
      r = s ? 0 : m_row;
      pix[r][c] = d;
      if (!s && r >= H - 1 && c >= W - 1) begin
        exp_v   = 1'b1;
        exp_col = 16'(c - 1);
        exp_row = 16'(r - 1);
        for (int i = 0; i < H; i++)
          for (int j = 0; j < W; j++)
            exp_w[i][j] = pix[r-2+i][c-2+j];
      end
      m_col = c + 1;
      m_row = r;
      if (m_col == IW) begin
        m_col = 0;
        m_row = r + 1;
        if (m_row == IH) m_row = 0;
      end
    end
    valid_i = 1'b0;
    sof_i   = 1'b0;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    step(1'b0, 16'h0000, 1'b0);
    rst_i   = 1'b0;
    m_col   = 0;
    m_row   = 0;
    exp_col = '0;
    exp_row = '0;
  endtask

  // Sends n pixels of the raster from the model position, with gap_pct% idle cycles.
  task automatic drive_frame(input logic [15:0] xorv, input int gap_pct, input int n);
    int sent;
    logic g;
    sent = 0;
    while (sent < n) begin
      g = (gap_pct > 0) && (int'($urandom_range(99)) < gap_pct);
      step(!g, {8'(m_row), 8'(m_col)} ^ xorv, 1'b0);
      if (!g) sent++;
      n_checks++;
      if (valid_o !== exp_v) begin
        n_fail++;
        $display("FAIL valid_o: got %0b expected %0b at %0t", valid_o, exp_v, $time);
      end
      n_checks++;
      if (col_o !== exp_col || row_o !== exp_row) begin
        n_fail++;
        $display("FAIL col_row: got (%0d,%0d) expected (%0d,%0d) at %0t",
                 col_o, row_o, exp_col, exp_row, $time);
      end
      if (exp_v) begin
        n_checks++;
        if (window_o !== exp_w) begin
          n_fail++;
          $display("FAIL window: got %h expected %h at %0t", window_o, exp_w, $time);
        end
      end
      if (valid_o === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", valid_o); end
    n_checks++;
    if (col_o !== 16'd0 || row_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_pos: got (%0d,%0d) expected (0,0)", col_o, row_o);
    end
    n_checks++;
    if (window_o !== '0) begin n_fail++; $display("FAIL reset_window: got %h expected 0", window_o); end
  endtask

  task automatic test_continuous();
    pulses = 0;
    drive_frame(16'h0000, 0, 19);
    n_checks++;
    if (valid_o !== 1'b1 || col_o !== 16'd1 || row_o !== 16'd1 || window_o[0][0] !== 16'h0000 ||
        window_o[1][1] !== 16'h0101 || window_o[2][2] !== 16'h0202) begin
      n_fail++;
      $display("FAIL first_window: got v=%0b (%0d,%0d) %h %h %h expected v=1 (1,1) 0000 0101 0202",
               valid_o, col_o, row_o, window_o[0][0], window_o[1][1], window_o[2][2]);
    end
    drive_frame(16'h0000, 0, 5);
    n_checks++;
    if (valid_o !== 1'b1 || col_o !== 16'd6 || row_o !== 16'd1 || window_o[2][2] !== 16'h0207) begin
      n_fail++;
      $display("FAIL row_end: got v=%0b (%0d,%0d) %h expected v=1 (6,1) 0207",
               valid_o, col_o, row_o, window_o[2][2]);
    end
    for (int i = 0; i < 2; i++) begin
      drive_frame(16'h0000, 0, 1);
      n_checks++;
      if (valid_o !== 1'b0) begin
        n_fail++; $display("FAIL row_head_%0d: got valid_o=%0b expected 0", i, valid_o);
      end
    end
    drive_frame(16'h0000, 0, 1);
    n_checks++;
    if (valid_o !== 1'b1 || col_o !== 16'd1 || row_o !== 16'd2) begin
      n_fail++;
      $display("FAIL row2_first: got v=%0b (%0d,%0d) expected v=1 (1,2)", valid_o, col_o, row_o);
    end
    drive_frame(16'h0000, 0, 21);
    n_checks++;
    if (pulses !== 24) begin n_fail++; $display("FAIL cont_pulses: got %0d expected 24", pulses); end
  endtask

  task automatic test_gaps();
    pulses = 0;
    drive_frame(16'h0000, 50, 48);
    n_checks++;
    if (pulses !== 24) begin n_fail++; $display("FAIL gap_pulses: got %0d expected 24", pulses); end
  endtask

  task automatic test_reset_mid();
    drive_frame(16'h0000, 0, 29);
    apply_reset();
    n_checks++;
    if (valid_o !== 1'b0 || col_o !== 16'd0 || row_o !== 16'd0 || window_o !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%0b (%0d,%0d) %h expected v=0 (0,0) 0",
               valid_o, col_o, row_o, window_o);
    end
    pulses = 0;
    drive_frame(16'h8000, 0, 48);
    n_checks++;
    if (pulses !== 24) begin n_fail++; $display("FAIL post_reset_pulses: got %0d expected 24", pulses); end
  endtask

  task automatic test_back_to_back();
    pulses = 0;
    drive_frame(16'h0000, 0, 48);
    n_checks++;
    if (pulses !== 24) begin n_fail++; $display("FAIL b2b_pulses_1: got %0d expected 24", pulses); end
    pulses = 0;
    drive_frame(16'h8000, 0, 19);
    n_checks++;
    if (valid_o !== 1'b1 || col_o !== 16'd1 || row_o !== 16'd1 || window_o[0][0] !== 16'h8000) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%0b (%0d,%0d) %h expected v=1 (1,1) 8000",
               valid_o, col_o, row_o, window_o[0][0]);
    end
    drive_frame(16'h8000, 0, 29);
    n_checks++;
    if (pulses !== 24) begin n_fail++; $display("FAIL b2b_pulses_2: got %0d expected 24", pulses); end
  endtask

`ifdef WINDOW_GEN_SOF_EN
  task automatic test_sof();
    drive_frame(16'h0000, 0, 20);
    step(1'b1, 16'h4000, 1'b1);
    n_checks++;
    if (valid_o !== 1'b0 || valid_o !== exp_v) begin
      n_fail++; $display("FAIL sof_edge: got valid_o=%0b expected 0", valid_o);
    end
    pulses = 0;
    drive_frame(16'h4000, 0, 17);
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL sof_early: got %0d pulses expected 0", pulses); end
    drive_frame(16'h4000, 0, 1);
    n_checks++;
    if (valid_o !== 1'b1 || col_o !== 16'd1 || row_o !== 16'd1 || window_o[0][0] !== 16'h4000) begin
      n_fail++;
      $display("FAIL sof_first: got v=%0b (%0d,%0d) %h expected v=1 (1,1) 4000",
               valid_o, col_o, row_o, window_o[0][0]);
    end
    drive_frame(16'h4000, 0, 29);
    n_checks++;
    if (pulses !== 24) begin n_fail++; $display("FAIL sof_pulses: got %0d expected 24", pulses); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pulses   = 0;
    valid_i  = 1'b0;
    sof_i    = 1'b0;
    data_i   = '0;
    rst_i    = 1'b1;
    exp_v    = 1'b0;
    exp_w    = '0;
    test_reset();
    test_continuous();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
`ifdef WINDOW_GEN_SOF_EN
    test_sof();
`else
    $display("sof_i port not present in this build");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
